// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant, {x,y,V} owner
// encoding, and an optional hold timeout that reclaims a stuck grant.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CW       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] D,
    input  logic       done,
    output logic [3:0] grant,
    output logic       x,
    output logic       y,
    output logic       V,
    output logic       timeout
);

    localparam bit             TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [CW-1:0]  HOLD_LAST  = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [CW-1:0]  CNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [CW-1:0] cnt;
    logic [1:0]    pick;
    logic          found;

    // First requester in rotating order ptr-1, ptr-2, ptr-3, ptr (mod 4).
    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            logic [1:0] idx;
            idx = 2'(ptr - 2'(i));
            if (!found && D[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Arbitration FSM; all outputs registered, reset drops the grant at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= 4'b0000;
            x       <= 1'b0;
            y       <= 1'b0;
            V       <= 1'b0;
            timeout <= 1'b0;
            ptr     <= 2'd0;
            cnt     <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= 4'(4'b0001 << pick);
                        x     <= pick[1];
                        y     <= pick[0];
                        V     <= 1'b1;
                        ptr   <= pick;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (done || !D[ptr]) begin
                        grant <= 4'b0000;
                        x     <= 1'b0;
                        y     <= 1'b0;
                        V     <= 1'b0;
                        state <= GAP;
                    end else if (TIMEOUT_EN && (cnt == HOLD_LAST)) begin
                        grant   <= 4'b0000;
                        x       <= 1'b0;
                        y       <= 1'b0;
                        V       <= 1'b0;
                        timeout <= 1'b1;
                        state   <= GAP;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4; observed word is {grant, x, y, V, timeout}.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] D;
    logic       done;
    logic [3:0] grant;
    logic       x;
    logic       y;
    logic       V;
    logic       timeout;
    logic [7:0] obs;

    int total = 0;
    int bad   = 0;

    rr_arbiter4 #(.MAX_HOLD(8), .CW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .D       (D),
        .done    (done),
        .grant   (grant),
        .x       (x),
        .y       (y),
        .V       (V),
        .timeout (timeout)
    );

    assign obs = {grant, x, y, V, timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] IDLE_O = 8'b0000_00_0_0;
    localparam logic [7:0] G3     = 8'b1000_11_1_0;
    localparam logic [7:0] G2     = 8'b0100_10_1_0;
    localparam logic [7:0] G1     = 8'b0010_01_1_0;
    localparam logic [7:0] G0     = 8'b0001_00_1_0;
    localparam logic [7:0] TO_O   = 8'b0000_00_0_1;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] rr_exp [5];

    initial begin
        rr_exp[0] = G3; rr_exp[1] = G2; rr_exp[2] = G1; rr_exp[3] = G0; rr_exp[4] = G3;
        rst  = 1'b1;
        D    = 4'b0000;
        done = 1'b0;
        #3;
        chk("reset", obs, IDLE_O);
        step();
        step();
        rst = 1'b0;

        // 1: full rotation with D=1111
        D = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("rr_grant%0d", k), obs, rr_exp[k]);
            done = 1'b1;
            step();
            done = 1'b0;
            chk($sformatf("rr_rel%0d", k), obs, IDLE_O);
            step();
            chk($sformatf("rr_gap%0d", k), obs, IDLE_O);
        end
        D = 4'b0000;
        step();
        chk("idle_no_req", obs, IDLE_O);

        // 2: single requester 0, done after 3 cycles, then re-grant
        D = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("r0_hold%0d", k), obs, G0);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        chk("r0_rel", obs, IDLE_O);
        step();
        chk("r0_gap", obs, IDLE_O);
        step();
        chk("r0_regrant", obs, G0);
        D    = 4'b0000;
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        chk("r0_back_idle", obs, IDLE_O);

        // 3: timeout after exactly 8 cycles
        D = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("to_hold%0d", k), obs, G2);
        end
        step();
        chk("to_pulse", obs, TO_O);
        step();
        chk("to_pulse_end", obs, IDLE_O);

        // 4: owner withdraws, then rotation from ptr=2
        step();
        chk("wd_grant", obs, G2);
        D = 4'b0000;
        step();
        chk("wd_rel_no_to", obs, IDLE_O);
        step();
        chk("wd_gap", obs, IDLE_O);
        D = 4'b1010;
        step();
        chk("wd_next_r1", obs, G1);

        // 6: done coincides with timeout condition
        for (int k = 1; k < 8; k++) begin
            step();
            chk($sformatf("dt_hold%0d", k), obs, G1);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        chk("dt_no_pulse", obs, IDLE_O);
        step();
        chk("dt_gap", obs, IDLE_O);
        step();
        chk("dt_next_r3", obs, G3);

        // 5: async reset mid-BUSY
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", obs, IDLE_O);
        #1;
        rst = 1'b0;
        D   = 4'b1111;
        step();
        chk("post_rst_r3", obs, G3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
